// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory port between an instruction-fetch
// requester and a data (load/store) requester. Data normally wins, but a
// streak counter bounds how many back-to-back data grants can starve a
// waiting fetch. The granted transaction is latched onto the bus_* registers
// and held until the memory signals bus_ready.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iren,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [31:0]       iload,
    input  logic              dread,
    input  logic [1:0]        dwrite,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dstore,
    output logic              dhit,
    output logic [31:0]       dload,
    output logic              bus_req,
    output logic              bus_wen,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ready
);

    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                bus_wen_q, bus_wen_d;
    logic [1:0]          bus_size_q, bus_size_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;

    logic dpend;
    logic starve;
    logic grant_i;
    logic grant_d;

    assign dpend  = dread | (dwrite != 2'b00);
    assign starve = iren & (streak_q == STREAK_MAX);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant decision: only IDLE looks at requests.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (starve) begin
                    grant_i = 1'b1;
                    state_d = IBUSY;
                end else if (dpend) begin
                    grant_d = 1'b1;
                    state_d = DBUSY;
                end else if (iren) begin
                    grant_i = 1'b1;
                    state_d = IBUSY;
                end
            end
            IBUSY:   if (bus_ready) state_d = IDLE;
            DBUSY:   if (bus_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state and the memory handshake.
    always_comb begin
        bus_req = (state_q == IBUSY) || (state_q == DBUSY);
        ihit    = (state_q == IBUSY) && bus_ready;
        dhit    = (state_q == DBUSY) && bus_ready;
        iload   = ihit ? bus_rdata : 32'h0;
        dload   = (dhit && !bus_wen_q) ? bus_rdata : 32'h0;
    end

    // Transaction fields and streak are captured only at a grant.
    always_comb begin
        streak_d    = streak_q;
        bus_wen_d   = bus_wen_q;
        bus_size_d  = bus_size_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if (grant_d) begin
            bus_addr_d  = daddr;
            bus_wen_d   = (dwrite != 2'b00);
            bus_size_d  = (dwrite != 2'b00) ? dwrite : 2'b11;
            bus_wdata_d = dstore;
            if (!iren) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end else if (grant_i) begin
            bus_addr_d  = iaddr;
            bus_wen_d   = 1'b0;
            bus_size_d  = 2'b11;
            bus_wdata_d = 32'h0;
            streak_d    = '0;
        end
    end

    // Latched bus fields and starvation streak.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q    <= '0;
            bus_wen_q   <= 1'b0;
            bus_size_q  <= 2'b00;
            bus_addr_q  <= '0;
            bus_wdata_q <= 32'h0;
        end else begin
            streak_q    <= streak_d;
            bus_wen_q   <= bus_wen_d;
            bus_size_q  <= bus_size_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus_wen   = bus_wen_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a transaction-level reference model predicts
// which requester owns the bus each cycle and what the hit outputs must be.
module tb_mem_arbiter;

    localparam int LIMIT = 3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iren = 1'b0;
    logic [31:0] iaddr = '0;
    logic        ihit;
    logic [31:0] iload;
    logic        dread = 1'b0;
    logic [1:0]  dwrite = 2'b00;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dhit;
    logic [31:0] dload;
    logic        bus_req;
    logic        bus_wen;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ready = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iren(iren), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dread(dread), .dwrite(dwrite), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 CLK = ~CLK;

    // Reference model: the outstanding transaction (if any) and the number
    // of data grants handed out in a row while a fetch was waiting.
    typedef struct {
        bit          busy;
        bit          is_fetch;
        logic [31:0] addr;
        bit          wen;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;

    txn_t m_txn;
    int   m_streak;
    bit   obs_ihit, obs_dhit;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_txn    = '{busy: 0, is_fetch: 0, addr: '0, wen: 0, size: 2'b00, wdata: '0};
        m_streak = 0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // then advance the model to what the rising edge will do.
    task automatic cycle(input bit rst, input bit ir, input logic [31:0] ia,
                         input bit dr, input logic [1:0] dw, input logic [31:0] da,
                         input logic [31:0] ds, input bit rdy, input logic [31:0] rd);
        bit   dp, exp_ih, exp_dh;
        @(negedge CLK);
        iren = ir; iaddr = ia; dread = dr; dwrite = dw; daddr = da; dstore = ds;
        bus_ready = rdy; bus_rdata = rd;
        nRST = !rst;
        #1;
        obs_ihit = ihit;
        obs_dhit = dhit;
        if (rst) begin
            model_reset();
            check("rst_bus_req", bus_req, 0);
            check("rst_ihit", ihit, 0);
            check("rst_dhit", dhit, 0);
            check("rst_iload", iload, 0);
            check("rst_dload", dload, 0);
            check("rst_bus_wen", bus_wen, 0);
            check("rst_bus_size", bus_size, 0);
            check("rst_bus_addr", bus_addr, 0);
            check("rst_bus_wdata", bus_wdata, 0);
            return;
        end
        exp_ih = m_txn.busy && m_txn.is_fetch && rdy;
        exp_dh = m_txn.busy && !m_txn.is_fetch && rdy;
        check("bus_req", bus_req, m_txn.busy);
        check("ihit", ihit, exp_ih);
        check("dhit", dhit, exp_dh);
        check("iload", iload, exp_ih ? rd : 32'h0);
        check("dload", dload, (exp_dh && !m_txn.wen) ? rd : 32'h0);
        if (m_txn.busy) begin
            check("bus_addr", bus_addr, m_txn.addr);
            check("bus_wen", bus_wen, m_txn.wen);
            check("bus_size", bus_size, m_txn.size);
            check("bus_wdata", bus_wdata, m_txn.wdata);
        end
        if (m_txn.busy) begin
            if (rdy) m_txn.busy = 0;
        end else begin
            dp = dr || (dw != 2'b00);
            if (ir && (m_streak == LIMIT || !dp)) begin
                m_txn = '{busy: 1, is_fetch: 1, addr: ia, wen: 0, size: 2'b11, wdata: '0};
                m_streak = 0;
            end else if (dp) begin
                m_txn = '{busy: 1, is_fetch: 0, addr: da, wen: (dw != 2'b00),
                          size: (dw != 2'b00) ? dw : 2'b11, wdata: ds};
                m_streak = ir ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
            end
        end
    endtask

    task automatic idle_cycle();
        cycle(0, 0, '0, 0, 2'b00, '0, '0, 0, '0);
    endtask

    initial begin
        int   nd, ni, nhits;
        bit   seq [5];
        model_reset();

        // Reset state
        cycle(1, 1, 32'h44, 1, 2'b11, 32'h55, 32'h66, 1, 32'h77);
        idle_cycle();

        // Fetch only: grant edge, then one busy cycle with ready
        cycle(0, 1, 32'h100, 0, 2'b00, '0, '0, 0, '0);
        cycle(0, 0, '0, 0, 2'b00, '0, '0, 1, 32'hDEADBEEF);
        check("fetch_only_ihit", obs_ihit, 1);
        idle_cycle();
        check("fetch_only_release", bus_req, 0);

        // Simultaneous requests, ready tied high: D grant, dhit, I grant, ihit
        cycle(0, 1, 32'h400, 1, 2'b00, 32'h2000, '0, 1, 32'h11);
        cycle(0, 1, 32'h400, 0, 2'b00, 32'h2000, '0, 1, 32'h22);
        check("simul_dhit_first", obs_dhit, 1);
        cycle(0, 1, 32'h400, 0, 2'b00, '0, '0, 1, 32'h33);
        cycle(0, 0, '0, 0, 2'b00, '0, '0, 1, 32'h44);
        check("simul_ihit_second", obs_ihit, 1);
        idle_cycle();

        // Starvation: fetch waits behind exactly LIMIT data grants
        nhits = 0;
        for (int c = 0; c < 30 && nhits < 5; c++) begin
            cycle(0, 1, 32'h500, 1, 2'b00, 32'h600 + c, '0, 1, $urandom);
            if (obs_ihit || obs_dhit) begin
                seq[nhits] = obs_ihit;
                nhits++;
            end
        end
        check("starve_hits", nhits, 5);
        check("starve_order", {seq[0], seq[1], seq[2], seq[3], seq[4]}, 5'b00010);
        idle_cycle();
        idle_cycle();

        // Byte store with 3 wait cycles, request dropped after grant
        nd = 0;
        cycle(0, 0, '0, 0, 2'b01, 32'h3, 32'hAB, 0, '0);
        for (int c = 0; c < 3; c++) begin
            cycle(0, 0, '0, 1, 2'b10, 32'hFFF0, 32'h1234, 0, '0);
            check("store_wait_nohit", obs_dhit, 0);
        end
        cycle(0, 0, '0, 0, 2'b00, '0, '0, 1, 32'hCAFE);
        if (obs_dhit) nd++;
        idle_cycle();
        if (obs_dhit) nd++;
        check("store_single_dhit", nd, 1);

        // Load dropped one cycle after grant still completes
        cycle(0, 0, '0, 1, 2'b00, 32'h8000, '0, 0, '0);
        cycle(0, 0, '0, 0, 2'b00, 32'h9000, '0, 0, '0);
        cycle(0, 0, '0, 0, 2'b00, 32'h9000, '0, 1, 32'h5A5A);
        check("drop_dhit", obs_dhit, 1);

        // Reset during a data wait abandons it; data wins first afterwards
        cycle(0, 0, '0, 1, 2'b00, 32'hA000, '0, 0, '0);
        cycle(0, 0, '0, 0, 2'b00, '0, '0, 0, '0);
        cycle(1, 0, '0, 0, 2'b00, '0, '0, 1, 32'h1);
        cycle(0, 0, '0, 0, 2'b00, '0, '0, 1, 32'h2);
        check("post_rst_no_dhit", obs_dhit, 0);
        ni = 0;
        cycle(0, 1, 32'hB00, 1, 2'b00, 32'hC00, '0, 1, '0);
        cycle(0, 0, '0, 0, 2'b00, '0, '0, 1, 32'h3);
        check("post_rst_data_first", obs_dhit, 1);
        idle_cycle();

        // Randomized traffic, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            bit          r_rst, r_ir, r_dr, r_rdy;
            logic [1:0]  r_dw;
            r_rst = ($urandom_range(0, 63) == 0);
            r_ir  = $urandom_range(0, 1);
            r_dr  = ($urandom_range(0, 9) < 4);
            r_dw  = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_rdy = ($urandom_range(0, 9) < 6);
            cycle(r_rst, r_ir, $urandom, r_dr, r_dw, $urandom, $urandom, r_rdy, $urandom);
            if (obs_ihit) ni++;
        end
        check("random_fetch_activity", ni > 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the maximum number of consecutive data grants allowed while a fetch request is waiting.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width (word_t).
REQ-003 SHALL use one clock and an asynchronous active-low reset, with ports as below.
REQ-004 CLK  in  1  system clock; all state updates on rising edge.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 iren  in  1  fetch read request.
REQ-007 iaddr  in  ADDR_W  fetch address.
REQ-008 ihit  out  1  fetch transaction complete this cycle.
REQ-009 iload  out  32  fetch read data, valid when ihit=1.
REQ-010 dread  in  1  memory-stage load request.
REQ-011 dwrite  in  2  memory-stage store request: 00 none, 01 byte, 10 half, 11 word.
REQ-012 daddr  in  ADDR_W  data address.
REQ-013 dstore  in  32  store data.
REQ-014 dhit  out  1  data transaction complete this cycle.
REQ-015 dload  out  32  load data, valid when dhit=1.
REQ-016 bus_req  out  1  shared memory port request.
REQ-017 bus_wen  out  1  1 = write.
REQ-018 bus_size  out  2  access size, same encoding as dwrite; 11 for all reads.
REQ-019 bus_addr  out  ADDR_W  latched transaction address.
REQ-020 bus_wdata  out  32  latched store data.
REQ-021 bus_rdata  in  32  read data from memory.
REQ-022 bus_ready  in  1  memory completes the current transaction this cycle.

Function
REQ-023 SHALL implement the FSM states IDLE, IBUSY and DBUSY.
REQ-024 A data request is pending when dread=1 or dwrite!=00.
- If dread=1 and dwrite!=00 together, the store wins.
REQ-025 In IDLE, grant priority is data over fetch, except the fetch is granted when iren=1 and the streak counter equals STARVE_LIMIT.
REQ-026 On a grant, the arbiter SHALL latch address, wen, size and wdata into bus_* registers and enter the busy state on the next edge.
- A data grant loads daddr, (dwrite!=00), dwrite or 11, and dstore.
- A fetch grant loads iaddr, 0, 11, and 0.
REQ-027 bus_req SHALL be 1 exactly in IBUSY and DBUSY.
REQ-028 bus_* outputs SHALL remain stable until bus_ready.
REQ-029 In IBUSY with bus_ready=1: ihit=1 and iload=bus_rdata combinationally, and the next state is IDLE.
REQ-030 In DBUSY with bus_ready=1: dhit=1 and dload=bus_rdata (or 0 on a write), and the next state is IDLE.
REQ-031 ihit and dhit SHALL never both be 1, and SHALL be 0 outside the matching busy state.
REQ-032 Changes on request inputs while busy SHALL be ignored; the latched transaction completes and hit pulses regardless.
REQ-033 Minimum latency from request to hit SHALL be 2 cycles: the grant edge, then a busy cycle with bus_ready=1.
- Each wait cycle with bus_ready=0 adds 1 cycle.
REQ-034 The streak counter (width clog2(STARVE_LIMIT+1)) SHALL update only on a grant.
- Data grant with iren=1: increment, saturating at STARVE_LIMIT.
- Data grant with iren=0: clear to 0.
- Fetch grant: clear to 0.
REQ-035 bus_ready in IDLE SHALL be ignored.
REQ-036 With no request in IDLE, the arbiter SHALL stay in IDLE with bus_req=0.

Reset
REQ-037 While nRST=0, immediately and asynchronously:
- state=IDLE, streak=0, bus_req=0, bus_wen=0, bus_size=00, bus_addr=0, bus_wdata=0;
- ihit=dhit=0, iload=dload=0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction with no hit.
- After release, the first grant follows REQ-025 from a zero streak.

Verification
REQ-039 Fetch only: iren=1, iaddr=0x100, bus_ready high in the 2nd cycle -> bus_req=1 for 1 cycle, bus_size=11, ihit=1 with iload=bus_rdata=0xDEADBEEF.
REQ-040 Simultaneous requests: iren=1, dread=1, daddr=0x2000 -> data granted first, dhit; then fetch granted, ihit; exactly 4 cycles with bus_ready tied high.
REQ-041 Starvation: STARVE_LIMIT=3, iren held high, a new data request each IDLE cycle -> 3 dhit pulses, then ihit, then the data request is served again.
REQ-042 Byte store: dwrite=01, daddr=0x3, dstore=0xAB, bus_ready delayed 3 cycles -> bus_wen=1, bus_size=01, bus_addr and bus_wdata stable for 4 busy cycles, then a single dhit.
REQ-043 Reset mid-DBUSY: drop nRST during a wait -> bus_req=0 immediately, no dhit, state IDLE, streak=0.
REQ-044 Request dropped while busy: dread deasserted one cycle after grant -> transaction still completes with a dhit pulse and the bus_addr latched at grant.
